// File: rtl/bus_mux_arb_if.sv
// Bus multiplexer/arbiter interface.
// Bundles the source data, drive requests, control inputs and the registered
// bus outputs of bus_mux_arb.
//   master : request/data side (register file, ALU, control unit)
//   slave  : the arbiter itself
// Signals:
//   reg_data       NREG*WIDTH  register outputs, r[i] = reg_data[i*WIDTH +: WIDTH]
//   aluout         WIDTH       ALU result
//   din            WIDTH       external data-in
//   din_enable     1           DIN drive request
//   gout           1           ALU drive request
//   rout_en        1           register drive request
//   rout           SELW        register index
//   lock           1           freeze bus contents, ignore requests
//   cnt_clr        1           clear contention counter
//   buswires       WIDTH       registered bus value
//   bus_src        2           0 none/reset, 1 REG, 2 ALU, 3 DIN
//   bus_valid      1           buswires granted this cycle
//   contention_cnt CNT_W       saturating contended-cycle count
interface bus_mux_arb_if #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int SELW  = $clog2(NREG),
  parameter int CNT_W = 8
);
  logic [NREG*WIDTH-1:0] reg_data;
  logic [WIDTH-1:0]      aluout;
  logic [WIDTH-1:0]      din;
  logic                  din_enable;
  logic                  gout;
  logic                  rout_en;
  logic [SELW-1:0]       rout;
  logic                  lock;
  logic                  cnt_clr;
  logic [WIDTH-1:0]      buswires;
  logic [1:0]            bus_src;
  logic                  bus_valid;
  logic [CNT_W-1:0]      contention_cnt;

  modport master (
    output reg_data, aluout, din, din_enable, gout, rout_en, rout, lock, cnt_clr,
    input  buswires, bus_src, bus_valid, contention_cnt
  );

  modport slave (
    input  reg_data, aluout, din, din_enable, gout, rout_en, rout, lock, cnt_clr,
    output buswires, bus_src, bus_valid, contention_cnt
  );
endinterface

// File: rtl/bus_mux_arb.sv
// Registered bus multiplexer with fixed-priority or round-robin arbitration.
// Selects one of NREG registers, the ALU result or external data-in onto the
// shared bus one cycle after the request, tags the source, flags validity and
// counts cycles where two or more sources asked to drive.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    bus_mux_arb_if.slave (see interface header for signal list)
module bus_mux_arb #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int SELW    = $clog2(NREG),
  parameter int RR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  bus_mux_arb_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_REG  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_DIN  = 2'd3
  } src_e;

  localparam logic [SELW:0] NREG_LIM = (SELW+1)'(NREG);

  logic             din_req;
  logic             alu_req;
  logic             reg_req;
  logic             contended;
  logic [WIDTH-1:0] reg_sel;
  logic [WIDTH-1:0] grant_data;
  src_e             grant;
  src_e             last_grant;

  always_comb begin
    din_req   = bus.din_enable;
    alu_req   = bus.gout;
    // Out-of-range indices (possible when NREG is not a power of two) are no request.
    reg_req   = bus.rout_en && ({1'b0, bus.rout} < NREG_LIM);
    contended = (din_req && alu_req) || (din_req && reg_req) || (alu_req && reg_req);

    reg_sel = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.rout == SELW'(i)) reg_sel = bus.reg_data[i*WIDTH +: WIDTH];
    end

    // Round-robin ring DIN -> ALU -> REG -> DIN; search starts after last_grant.
    // last_grant resets to REG, so the first RR order equals fixed priority.
    grant = SRC_NONE;
    if (RR_MODE != 0 && last_grant == SRC_DIN) begin
      if (alu_req)      grant = SRC_ALU;
      else if (reg_req) grant = SRC_REG;
      else if (din_req) grant = SRC_DIN;
    end else if (RR_MODE != 0 && last_grant == SRC_ALU) begin
      if (reg_req)      grant = SRC_REG;
      else if (din_req) grant = SRC_DIN;
      else if (alu_req) grant = SRC_ALU;
    end else begin
      if (din_req)      grant = SRC_DIN;
      else if (alu_req) grant = SRC_ALU;
      else if (reg_req) grant = SRC_REG;
    end

    case (grant)
      SRC_DIN: grant_data = bus.din;
      SRC_ALU: grant_data = bus.aluout;
      default: grant_data = reg_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.buswires       <= '0;
      bus.bus_src        <= SRC_NONE;
      bus.bus_valid      <= 1'b0;
      bus.contention_cnt <= '0;
      last_grant         <= SRC_REG;
    end else begin
      if (!bus.lock && grant != SRC_NONE) begin
        bus.buswires  <= grant_data;
        bus.bus_src   <= grant;
        bus.bus_valid <= 1'b1;
        last_grant    <= grant;
      end else begin
        bus.bus_valid <= 1'b0;
      end

      if (bus.cnt_clr)
        bus.contention_cnt <= '0;
      else if (!bus.lock && contended && bus.contention_cnt != '1)
        bus.contention_cnt <= bus.contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Testbench: two arbiters share one stimulus stream.
//   dut_a: fixed priority, NREG=6, CNT_W=2
//   dut_b: round-robin,    NREG=8, CNT_W=8
module tb_bus_mux_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, din_enable, gout, rout_en, lock, cnt_clr;
  logic [2:0]  rout;
  logic [15:0] din, aluout;
  logic [15:0] regs [8];

  int checks = 0;
  int failures = 0;

  bus_mux_arb_if #(.WIDTH(16), .NREG(6), .CNT_W(2)) ifa ();
  bus_mux_arb_if #(.WIDTH(16), .NREG(8), .CNT_W(8)) ifb ();

  always_comb begin
    ifa.aluout = aluout;  ifa.din = din;  ifa.din_enable = din_enable;
    ifa.gout = gout;      ifa.rout_en = rout_en;  ifa.rout = rout;
    ifa.lock = lock;      ifa.cnt_clr = cnt_clr;
    ifb.aluout = aluout;  ifb.din = din;  ifb.din_enable = din_enable;
    ifb.gout = gout;      ifb.rout_en = rout_en;  ifb.rout = rout;
    ifb.lock = lock;      ifb.cnt_clr = cnt_clr;
    for (int i = 0; i < 6; i++) ifa.reg_data[i*16 +: 16] = regs[i];
    for (int i = 0; i < 8; i++) ifb.reg_data[i*16 +: 16] = regs[i];
  end

  bus_mux_arb #(.WIDTH(16), .NREG(6), .RR_MODE(0), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  bus_mux_arb #(.WIDTH(16), .NREG(8), .RR_MODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  // Reference model state, index 0 = dut_a, 1 = dut_b. Source codes double
  // as fixed priority (higher code wins).
  int m_bus [2];
  int m_src [2];
  int m_valid [2];
  int m_cnt [2];
  int m_last [2];

  task automatic model_step(input int k);
    int nreg, cmax, g, c, n;
    bit req [4];
    nreg = (k == 0) ? 6 : 8;
    cmax = (k == 0) ? 3 : 255;
    if (!rst_n) begin
      m_bus[k] = 0; m_src[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
      return;
    end
    req[0] = 0;
    req[3] = din_enable;
    req[2] = gout;
    req[1] = rout_en && (int'(rout) < nreg);
    n = int'(req[1]) + int'(req[2]) + int'(req[3]);
    g = 0;
    if (!lock) begin
      if (k == 1) begin
        c = m_last[k];
        for (int s = 0; s < 3; s++) begin
          c = (c == 1) ? 3 : c - 1;
          if (g == 0 && req[c]) g = c;
        end
      end else begin
        for (int s = 3; s >= 1; s--) if (g == 0 && req[s]) g = s;
      end
    end
    if (g != 0) begin
      m_bus[k] = (g == 3) ? int'(din) : (g == 2) ? int'(aluout) : int'(regs[rout]);
      m_src[k] = g; m_valid[k] = 1; m_last[k] = g;
    end else begin
      m_valid[k] = 0;
    end
    if (cnt_clr) m_cnt[k] = 0;
    else if (!lock && n >= 2 && m_cnt[k] < cmax) m_cnt[k]++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic de, input logic g, input logic re,
                        input logic [2:0] ro, input logic lk, input logic cl);
    rst_n = r; din_enable = de; gout = g; rout_en = re; rout = ro; lock = lk; cnt_clr = cl;
  endtask

  // One clock: update model from the inputs about to be sampled, then check
  // both DUTs 1 time unit after the edge.
  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk("a_bus",   32'(ifa.buswires),       32'(m_bus[0]));
    chk("a_src",   32'(ifa.bus_src),        32'(m_src[0]));
    chk("a_valid", 32'(ifa.bus_valid),      32'(m_valid[0]));
    chk("a_cnt",   32'(ifa.contention_cnt), 32'(m_cnt[0]));
    chk("b_bus",   32'(ifb.buswires),       32'(m_bus[1]));
    chk("b_src",   32'(ifb.bus_src),        32'(m_src[1]));
    chk("b_valid", 32'(ifb.bus_valid),      32'(m_valid[1]));
    chk("b_cnt",   32'(ifb.contention_cnt), 32'(m_cnt[1]));
  endtask

  typedef struct {
    logic        rst_n, din_en, gout, rout_en;
    logic [2:0]  rout;
    logic        lock, clr;
    logic [15:0] bus;
    logic [1:0]  src;
    logic        valid;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs [16];
  int   rr_exp [6];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_bus[k] = 0; m_src[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
    end
    din = 16'hAAAA; aluout = 16'h5555;
    regs[0] = 16'h0F0F; regs[1] = 16'h1111; regs[2] = 16'h2222; regs[3] = 16'h1234;
    regs[4] = 16'h4444; regs[5] = 16'h5A5A; regs[6] = 16'h6666; regs[7] = 16'h7777;

    // Fixed-priority dut_a (NREG=6, CNT_W=2) expectations, derived by hand.
    //          rst  de  g   re  rout  lk  cl   bus       src  v  cnt
    vecs[0]  = '{0, 1, 1, 1, 3'd3, 1, 0, 16'h0000, 2'd0, 0, 2'd0}; // reset beats lock
    vecs[1]  = '{1, 0, 0, 1, 3'd3, 0, 0, 16'h1234, 2'd1, 1, 2'd0};
    vecs[2]  = '{1, 1, 1, 1, 3'd0, 0, 0, 16'hAAAA, 2'd3, 1, 2'd1};
    vecs[3]  = '{1, 1, 1, 1, 3'd0, 0, 0, 16'hAAAA, 2'd3, 1, 2'd2};
    vecs[4]  = '{1, 1, 1, 1, 3'd0, 0, 0, 16'hAAAA, 2'd3, 1, 2'd3};
    vecs[5]  = '{1, 1, 1, 1, 3'd0, 0, 0, 16'hAAAA, 2'd3, 1, 2'd3}; // saturated
    vecs[6]  = '{1, 0, 1, 1, 3'd0, 0, 0, 16'h5555, 2'd2, 1, 2'd3};
    vecs[7]  = '{1, 0, 0, 0, 3'd0, 0, 0, 16'h5555, 2'd2, 0, 2'd3}; // hold
    vecs[8]  = '{1, 0, 0, 1, 3'd7, 0, 0, 16'h5555, 2'd2, 0, 2'd3}; // out of range
    vecs[9]  = '{1, 0, 1, 1, 3'd6, 0, 0, 16'h5555, 2'd2, 1, 2'd3}; // rout=6 not a request
    vecs[10] = '{1, 1, 1, 1, 3'd0, 0, 1, 16'hAAAA, 2'd3, 1, 2'd0}; // clear wins
    vecs[11] = '{1, 1, 1, 0, 3'd0, 1, 0, 16'hAAAA, 2'd3, 0, 2'd0}; // lock
    vecs[12] = '{1, 1, 1, 0, 3'd0, 0, 0, 16'hAAAA, 2'd3, 1, 2'd1};
    vecs[13] = '{1, 0, 1, 1, 3'd5, 0, 0, 16'h5555, 2'd2, 1, 2'd2};
    vecs[14] = '{1, 0, 0, 1, 3'd5, 0, 0, 16'h5A5A, 2'd1, 1, 2'd2};
    vecs[15] = '{0, 0, 0, 0, 3'd0, 0, 0, 16'h0000, 2'd0, 0, 2'd0};

    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].rst_n, vecs[i].din_en, vecs[i].gout, vecs[i].rout_en,
             vecs[i].rout, vecs[i].lock, vecs[i].clr);
      cyc();
      chk($sformatf("vec%0d_bus", i),   32'(ifa.buswires),       32'(vecs[i].bus));
      chk($sformatf("vec%0d_src", i),   32'(ifa.bus_src),        32'(vecs[i].src));
      chk($sformatf("vec%0d_valid", i), 32'(ifa.bus_valid),      32'(vecs[i].valid));
      chk($sformatf("vec%0d_cnt", i),   32'(ifa.contention_cnt), 32'(vecs[i].cnt));
    end

    // Round-robin fairness on dut_b: all three classes held for 6 cycles.
    rr_exp[0] = 3; rr_exp[1] = 2; rr_exp[2] = 1; rr_exp[3] = 3; rr_exp[4] = 2; rr_exp[5] = 1;
    set_in(0, 0, 0, 0, 3'd0, 0, 0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 1, 1, 3'd0, 0, 0);
      cyc();
      chk($sformatf("rr%0d_src", i), 32'(ifb.bus_src), 32'(rr_exp[i]));
      chk($sformatf("rr%0d_cnt", i), 32'(ifb.contention_cnt), 32'(i + 1));
      chk($sformatf("fx%0d_src", i), 32'(ifa.bus_src), 32'd3);
    end

    // Hold then lock on dut_b.
    aluout = 16'hBEEF;
    set_in(1, 0, 1, 0, 3'd0, 0, 0);
    cyc();
    chk("hold_grant_bus", 32'(ifb.buswires), 32'h0000BEEF);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 3'd0, 0, 0);
      cyc();
      chk("hold_bus",   32'(ifb.buswires),  32'h0000BEEF);
      chk("hold_src",   32'(ifb.bus_src),   32'd2);
      chk("hold_valid", 32'(ifb.bus_valid), 32'd0);
    end
    din = 16'h0001;
    set_in(1, 1, 1, 0, 3'd0, 1, 0);
    cyc();
    chk("lock_bus",   32'(ifb.buswires),       32'h0000BEEF);
    chk("lock_valid", 32'(ifb.bus_valid),      32'd0);
    chk("lock_cnt",   32'(ifb.contention_cnt), 32'd6);
    // Release: RR resumes after ALU, so REG wins over DIN.
    set_in(1, 1, 0, 1, 3'd7, 0, 0);
    cyc();
    chk("release_src", 32'(ifb.bus_src),  32'd1);
    chk("release_bus", 32'(ifb.buswires), 32'h00007777);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      din    = 16'($urandom);
      aluout = 16'($urandom);
      for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
      set_in(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
